// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART state encodings and bit-timing helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t c_st_idle   = 3'd0;
    localparam uart_state_t c_st_start  = 3'd1;
    localparam uart_state_t c_st_recv   = 3'd2;
    localparam uart_state_t c_st_stop   = 3'd3;
    localparam uart_state_t c_st_parity = 3'd4;

    function automatic int cycles_per_bit(input int clk_freq, input int bit_rate);
        return clk_freq / bit_rate;
    endfunction

    function automatic int counter_width(input int max_value);
        return $clog2(max_value + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for the serial line plus a delay flop
//               for edge detection; all flops reset to the idle-high level.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_rxd,
    output logic o_rxd_s,
    output logic o_rxd_q
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rxd;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rxd_s = r_sync;
    assign o_rxd_q = r_prev;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver, centre-sampling, with framing-error and break
//               flags. Define UART_RX_PARITY_EN to expect an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_RATE      = 9600,
    parameter int CLK_FREQ      = 50_000_000,
    parameter int PAYLOAD_WIDTH = 8,
    parameter int STOP_BITS     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_rxd,
    input  logic                     uart_rx_en,
    output logic                     uart_rx_valid,
    output logic [PAYLOAD_WIDTH-1:0] uart_rx_data,
    output logic                     uart_rx_frame_err,
    output logic                     uart_rx_break,
`ifdef UART_RX_PARITY_EN
    output logic                     uart_rx_parity_err,
`endif
    output logic                     uart_rx_busy
);

    localparam int c_cycles_per_bit = cycles_per_bit(CLK_FREQ, BIT_RATE);
    localparam int c_half_bit       = c_cycles_per_bit / 2;
    localparam int c_cnt_w          = counter_width(c_cycles_per_bit);
    localparam int c_bcnt_w         = counter_width(PAYLOAD_WIDTH);

    localparam logic [c_cnt_w-1:0]  c_half_last = c_cnt_w'(c_half_bit - 1);
    localparam logic [c_cnt_w-1:0]  c_bit_last  = c_cnt_w'(c_cycles_per_bit - 1);
    localparam logic [c_bcnt_w-1:0] c_data_last = c_bcnt_w'(PAYLOAD_WIDTH - 1);
    localparam logic [c_bcnt_w-1:0] c_stop_last = c_bcnt_w'(STOP_BITS - 1);

    logic w_rxd_s;
    logic w_rxd_q;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_rxd   (uart_rxd),
        .o_rxd_s (w_rxd_s),
        .o_rxd_q (w_rxd_q)
    );

    uart_state_t              r_state;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [c_bcnt_w-1:0]      r_bit_cnt;
    logic [PAYLOAD_WIDTH-1:0] r_shift;
    logic                     r_err;
    logic                     r_armed;
    logic                     r_valid;
    logic [PAYLOAD_WIDTH-1:0] r_data;
    logic                     r_frame_err;
    logic                     r_break;
    logic                     r_busy;
`ifdef UART_RX_PARITY_EN
    logic                     r_par;
    logic                     r_parity_err;
`endif

    logic w_err_now;
    assign w_err_now = r_err | ~w_rxd_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_err       <= 1'b0;
            r_armed     <= 1'b1;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_frame_err <= 1'b0;
            r_break     <= 1'b0;
            r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_break     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                c_st_idle: begin
                    r_cnt <= '0;
                    // After an errored frame the line must return high first
                    if (!r_armed) begin
                        r_armed <= w_rxd_s;
                    end else if (uart_rx_en && w_rxd_q && !w_rxd_s) begin
                        r_state <= c_st_start;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_start: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                        if (w_rxd_s) begin
                            r_state <= c_st_idle;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= c_st_recv;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                c_st_recv: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxd_s, r_shift[PAYLOAD_WIDTH-1:1]};
                        if (r_bit_cnt == c_data_last) begin
                            r_bit_cnt <= '0;
                            r_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            r_state   <= c_st_parity;
`else
                            r_state   <= c_st_stop;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_bcnt_w'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                c_st_parity: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_par   <= w_rxd_s;
                        r_state <= c_st_stop;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
`endif
                c_st_stop: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt <= '0;
                        if (r_bit_cnt == c_stop_last) begin
                            r_state     <= c_st_idle;
                            r_busy      <= 1'b0;
                            r_bit_cnt   <= '0;
                            r_err       <= 1'b0;
                            r_armed     <= ~w_err_now;
                            r_valid     <= 1'b1;
                            r_data      <= r_shift;
                            r_frame_err <= w_err_now;
                            r_break     <= w_err_now & (r_shift == '0);
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= ^{r_shift, r_par};
`endif
                        end else begin
                            r_err     <= w_err_now;
                            r_bit_cnt <= r_bit_cnt + c_bcnt_w'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign uart_rx_valid     = r_valid;
    assign uart_rx_data      = r_data;
    assign uart_rx_frame_err = r_frame_err;
    assign uart_rx_break     = r_break;
    assign uart_rx_busy      = r_busy;
`ifdef UART_RX_PARITY_EN
    assign uart_rx_parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx with a queue-based
//               scoreboard of expected words, flags and arrival cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rxd;
    logic       uart_rx_en;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_rx_frame_err;
    logic       uart_rx_break;
    logic       uart_rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       uart_rx_parity_err;
`endif

    uart_rx #(
        .BIT_RATE      (100_000),
        .CLK_FREQ      (1_000_000),
        .PAYLOAD_WIDTH (8),
        .STOP_BITS     (1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .uart_rxd          (uart_rxd),
        .uart_rx_en        (uart_rx_en),
        .uart_rx_valid     (uart_rx_valid),
        .uart_rx_data      (uart_rx_data),
        .uart_rx_frame_err (uart_rx_frame_err),
        .uart_rx_break     (uart_rx_break),
`ifdef UART_RX_PARITY_EN
        .uart_rx_parity_err(uart_rx_parity_err),
`endif
        .uart_rx_busy      (uart_rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       brk;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every valid strobe must match the oldest queued frame
    always @(negedge clk) begin
        if (!rst && uart_rx_valid) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_valid observed=data %0h expected=no strobe", uart_rx_data);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("rx_data",  {24'd0, uart_rx_data},   {24'd0, e.data});
                check("rx_ferr",  {31'd0, uart_rx_frame_err}, {31'd0, e.ferr});
                check("rx_break", {31'd0, uart_rx_break},  {31'd0, e.brk});
                check("rx_latency", cyc, e.cyc);
            end
        end else if (!rst) begin
            tests++;
            assert ((uart_rx_frame_err === 1'b0) && (uart_rx_break === 1'b0)) else begin
                fails++;
                $error("FAIL flags_unqualified observed=%b%b expected=00", uart_rx_frame_err, uart_rx_break);
            end
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic ferr, input logic brk);
        exp_t e;
        e.data = d;
        e.ferr = ferr;
        e.brk  = brk;
        e.cyc  = cyc + 98;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; drives one full frame and returns at a negedge
    task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                              input bit expect_rx, input bit drop_en);
        uart_rxd = 1'b0;
        if (expect_rx) push_exp(d, ~stop_ok, ~stop_ok && (d == 8'h00));
        repeat (10) @(negedge clk);
        if (drop_en) uart_rx_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            repeat (10) @(negedge clk);
        end
        uart_rxd = stop_ok;
        repeat (10) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    initial begin
        logic [7:0] partial;
        rst        = 1'b1;
        uart_rx_en = 1'b0;
        uart_rxd   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_valid", {31'd0, uart_rx_valid},     32'd0);
        check("reset_data",  {24'd0, uart_rx_data},      32'd0);
        check("reset_ferr",  {31'd0, uart_rx_frame_err}, 32'd0);
        check("reset_break", {31'd0, uart_rx_break},     32'd0);
        check("reset_busy",  {31'd0, uart_rx_busy},      32'd0);
        rst        = 1'b0;
        uart_rx_en = 1'b1;
        repeat (5) @(negedge clk);

        // Clean frame
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        repeat (5) @(negedge clk);

        // Reset during data bit 4 of 0x5A; receiver held off until the line idles
        partial  = 8'h5A;
        uart_rxd = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = partial[i];
            repeat (10) @(negedge clk);
        end
        uart_rxd = partial[4];
        repeat (3) @(negedge clk);
        rst        = 1'b1;
        uart_rx_en = 1'b0;
        @(negedge clk);
        check("midrst_valid", {31'd0, uart_rx_valid},     32'd0);
        check("midrst_data",  {24'd0, uart_rx_data},      32'd0);
        check("midrst_ferr",  {31'd0, uart_rx_frame_err}, 32'd0);
        check("midrst_break", {31'd0, uart_rx_break},     32'd0);
        check("midrst_busy",  {31'd0, uart_rx_busy},      32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 5; i < 8; i++) begin
            uart_rxd = partial[i];
            repeat (10) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (15) @(negedge clk);
        check("midrst_idle_busy", {31'd0, uart_rx_busy}, 32'd0);
        uart_rx_en = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
        repeat (5) @(negedge clk);

        // Short glitch: start bit rejected at its centre
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch_busy_during", {31'd0, uart_rx_busy}, 32'd1);
        repeat (16) @(negedge clk);
        check("glitch_busy_after", {31'd0, uart_rx_busy}, 32'd0);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        repeat (5) @(negedge clk);

        // Framing error with non-zero data
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);

        // Break: line low for 20 bit times gives a single break strobe
        uart_rxd = 1'b0;
        push_exp(8'h00, 1'b1, 1'b1);
        repeat (200) @(negedge clk);
        check("break_no_rearm_busy", {31'd0, uart_rx_busy}, 32'd0);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h96, 1'b1, 1'b1, 1'b0);

        // Back-to-back frames, enable dropped during the second
        send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("en_low_busy", {31'd0, uart_rx_busy}, 32'd0);

        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
